// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N requesters.
// Define UART_TX_ARB_BURST_EN to let a grant keep the transmitter for up to MAX_BURST frames.
//
// state      | meaning
// IDLE       | arbitrate; grant when any REQ is set and TX_BUSY is low
// WAIT_START | frame issued, waiting for TX_BUSY to rise (timeout -> ERR)
// WAIT_DONE  | frame in flight, waiting for TX_BUSY to fall (-> ACK)
// BURST      | re-latch the current requester's next frame (burst build only)
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N*DW-1:0]      REQ_DATA,
  input  logic [N-1:0]         REQ_PAR_EN,
  output logic [N-1:0]         ACK,
  output logic                 ERR,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 GNT_VLD,
  output logic [DW-1:0]        TX_P_DATA,
  output logic                 TX_PAR_EN,
  output logic                 TX_DATA_VALID,
  input  logic                 TX_BUSY
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] WAIT_DONE  = 2'd2;
  localparam logic [1:0] BURST      = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [TW-1:0] cnt;
  logic [IW-1:0] win;
  logic          win_vld;
  logic [IW:0]   sum;

`ifdef UART_TX_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt;
`endif

  // Search downward so the candidate nearest LAST+1 is written last and wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (REQ[sum[IW-1:0]]) begin
        win     = sum[IW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      last          <= IW'(N - 1);
      cnt           <= '0;
      ACK           <= '0;
      ERR           <= 1'b0;
      GNT_ID        <= '0;
      GNT_VLD       <= 1'b0;
      TX_P_DATA     <= '0;
      TX_PAR_EN     <= 1'b0;
      TX_DATA_VALID <= 1'b0;
`ifdef UART_TX_ARB_BURST_EN
      burst_cnt     <= '0;
`endif
    end else begin
      ACK           <= '0;
      ERR           <= 1'b0;
      TX_DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld && !TX_BUSY) begin
            GNT_ID        <= win;
            GNT_VLD       <= 1'b1;
            TX_P_DATA     <= REQ_DATA[int'(win)*DW +: DW];
            TX_PAR_EN     <= REQ_PAR_EN[win];
            TX_DATA_VALID <= 1'b1;
            cnt           <= '0;
            state         <= WAIT_START;
`ifdef UART_TX_ARB_BURST_EN
            burst_cnt     <= BW'(1);
`endif
          end
        end
        WAIT_START: begin
          if (TX_BUSY) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            ERR     <= 1'b1;
            GNT_VLD <= 1'b0;
            last    <= GNT_ID;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            ACK[GNT_ID] <= 1'b1;
`ifdef UART_TX_ARB_BURST_EN
            if (REQ[GNT_ID] && (burst_cnt < BW'(MAX_BURST))) begin
              state <= BURST;
            end else begin
              GNT_VLD <= 1'b0;
              last    <= GNT_ID;
              state   <= IDLE;
            end
`else
            GNT_VLD <= 1'b0;
            last    <= GNT_ID;
            state   <= IDLE;
`endif
          end
        end
`ifdef UART_TX_ARB_BURST_EN
        // Grant is kept: next frame goes out regardless of TX_BUSY.
        BURST: begin
          TX_P_DATA     <= REQ_DATA[int'(GNT_ID)*DW +: DW];
          TX_PAR_EN     <= REQ_PAR_EN[GNT_ID];
          TX_DATA_VALID <= 1'b1;
          burst_cnt     <= burst_cnt + 1'b1;
          cnt           <= '0;
          state         <= WAIT_START;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
